mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dataEn  in  1  LS request strobe, one cycle.
- LSRW  in  1  0=read, 1=write.
- dataAddr  in  32  byte address of access.
- LSlen  in  2  00=byte, 01=half, 11=word.
- Sdata  in  32  store data, little-endian.
- LOutEn  out  1  one-cycle completion pulse, for reads and writes.
- Ldata  out  32  load result, zero-extended.
- LSfree  out  1  high when a new request is accepted.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1=RAM write this cycle.

Function
REQ-002 SHALL implement a state machine with states IDLE, RUN, DONE, plus WAIT when MEMCTRL_IO_WAIT_EN is defined.
REQ-003 SHALL assert LSfree combinationally in IDLE only.
REQ-004 SHALL accept a request only when dataEn=1 in IDLE, latching LSRW, dataAddr, LSlen and Sdata; dataEn outside IDLE SHALL be ignored.
REQ-005 SHALL set byte count n=1, 2, 4 for LSlen 00, 01, 11; LSlen 10 SHALL be treated as 11.
REQ-006 SHALL, when the request is accepted at edge T, drive byte i (i=0..n-1) in cycle T+1+i: mem_a=dataAddr+i (32-bit wrap), mem_wr=LSRW, mem_dout=Sdata[8i+7:8i].
REQ-007 SHALL, outside active write cycles, hold mem_wr=0 and mem_dout=0.
REQ-008 SHALL, for reads, treat RAM latency as one cycle and capture mem_din into Ldata byte i at the end of cycle T+2+i.
REQ-009 SHALL zero Ldata bytes >= n.
REQ-010 SHALL pulse LOutEn for exactly one cycle: cycle T+n+1 for writes, cycle T+n+2 for reads; Ldata SHALL be valid in that cycle and SHALL hold until the next accept.
REQ-011 SHALL return from DONE to IDLE, so the earliest next accept is the LOutEn cycle+1 edge, i.e. LSfree is high in the cycle after LOutEn.
REQ-012 SHALL keep Ldata=0 for writes.

Reset
REQ-013 SHALL, on rst=0 at any time including mid-access, immediately force: state=IDLE, LOutEn=0, Ldata=0, mem_a=0, mem_wr=0, mem_dout=0, and clear all latched request registers.
REQ-014 SHALL abandon an interrupted write; bytes already written are not rolled back.
REQ-015 SHALL raise LSfree in the first cycle after rst returns to 1.

Configuration
REQ-016 SHALL use the macro MEMCTRL_IO_WAIT_EN.
- Defined: an accepted request with dataAddr[17:16]=11 SHALL pass through one WAIT cycle before RUN, shifting every timing in REQ-006, REQ-008 and REQ-010 by +1 cycle.
- Undefined: there SHALL be no WAIT state and no address-dependent timing.

Verification
REQ-017 SW: addr=0x100, Sdata=0xA1B2C3D4 -> mem_a 0x100..0x103 with mem_dout D4,C3,B2,A1, mem_wr=1 in all four cycles; LOutEn at T+5.
REQ-018 LW: addr=0x100, RAM preloaded D4,C3,B2,A1 -> Ldata=0xA1B2C3D4, LOutEn at T+6.
REQ-019 LB: addr=0x103 and LH: addr=0x102 -> Ldata=0x000000A1 and 0x0000A1B2; LOutEn at T+3 and T+4.
REQ-020 SW at addr=0xFFFFFFFE -> mem_a FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-021 rst=0 during byte 2 of an SW -> next-cycle outputs are all zero, LSfree=1 after release, no LOutEn; dataEn held while busy produces no second access.
REQ-022 With MEMCTRL_IO_WAIT_EN defined, SB to 0x30000 -> mem_wr at T+2, LOutEn at T+3; SB to 0x100 -> unchanged timing.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises byte/half/word loads and stores onto a byte-wide RAM port, one byte per cycle.
// Latency: store n+1 cycles, load n+2 cycles from accept to LOutEn (n=1/2/4); optional MEMCTRL_IO_WAIT_EN adds +1 for dataAddr[17:16]=11.
// Backpressure: LSfree high only while idle; dataEn seen while busy is dropped, never queued.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        dataEn,
    input  logic        LSRW,
    input  logic [31:0] dataAddr,
    input  logic [1:0]  LSlen,
    input  logic [31:0] Sdata,
    output logic        LOutEn,
    output logic [31:0] Ldata,
    output logic        LSfree,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

`ifdef MEMCTRL_IO_WAIT_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t      state;
    state_t      state_nxt;

    // latched request
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [1:0]  last_q;     // index of the final byte (n-1)

    // byte sequencing and read-capture pipeline
    logic [2:0]  cnt;        // byte index currently on the RAM port
    logic        cap_vld;    // mem_din carries a load byte this cycle
    logic [1:0]  cap_idx;    // which Ldata byte it belongs to

    logic        accept;
    logic        active;
    logic        run_end;

    // State register; reset lands in IDLE so LSfree is up as soon as reset lifts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake outputs. Loads stay in RUN one cycle
    // longer than stores so the last RAM byte (one-cycle latency) is captured
    // on the same edge that enters DONE.
    always_comb begin
        state_nxt = state;
        LSfree    = 1'b0;
        LOutEn    = 1'b0;
        accept    = 1'b0;
        active    = 1'b0;
        run_end   = 1'b0;
        case (state)
            IDLE: begin
                LSfree = 1'b1;
                if (dataEn) begin
                    accept = 1'b1;
`ifdef MEMCTRL_IO_WAIT_EN
                    state_nxt = (dataAddr[17:16] == 2'b11) ? WAIT : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                active  = (cnt <= {1'b0, last_q});
                run_end = rw_q ? (cnt == {1'b0, last_q})
                               : (cnt == ({1'b0, last_q} + 3'd1));
                if (run_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                LOutEn    = 1'b1;
                state_nxt = IDLE;
            end
`ifdef MEMCTRL_IO_WAIT_EN
            WAIT: begin
                state_nxt = RUN;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RAM port: address/data only during byte cycles, everything else parked at zero.
    always_comb begin
        mem_wr   = active & rw_q;
        mem_a    = active ? (addr_q + {30'd0, cnt[1:0]}) : 32'd0;
        mem_dout = mem_wr ? sdata_q[{cnt[1:0], 3'b000} +: 8] : 8'd0;
    end

    // Request latch, byte counter and load-data assembly. Ldata is cleared on
    // accept so unused upper bytes and store results read back as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_q    <= 1'b0;
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
            last_q  <= 2'd0;
            cnt     <= 3'd0;
            cap_vld <= 1'b0;
            cap_idx <= 2'd0;
            Ldata   <= 32'd0;
        end else if (accept) begin
            rw_q    <= LSRW;
            addr_q  <= dataAddr;
            sdata_q <= Sdata;
            last_q  <= (LSlen == 2'b00) ? 2'd0 :
                       (LSlen == 2'b01) ? 2'd1 : 2'd3;
            cnt     <= 3'd0;
            cap_vld <= 1'b0;
            cap_idx <= 2'd0;
            Ldata   <= 32'd0;
        end else begin
            if (state == RUN) begin
                cnt <= cnt + 3'd1;
            end
            cap_vld <= active & ~rw_q;
            cap_idx <= cnt[1:0];
            if (cap_vld) begin
                Ldata[{cap_idx, 3'b000} +: 8] <= mem_din;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: random + directed load/store traffic against a byte RAM model, scoreboarded.
// Latency: expected access/completion cycles derived from request length and type.
// Backpressure: requests are only issued when LSfree is observed high.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dataEn = 1'b0;
    logic        LSRW = 1'b0;
    logic [31:0] dataAddr = 32'd0;
    logic [1:0]  LSlen = 2'd0;
    logic [31:0] Sdata = 32'd0;
    logic        LOutEn;
    logic [31:0] Ldata;
    logic        LSfree;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .dataEn   (dataEn),
        .LSRW     (LSRW),
        .dataAddr (dataAddr),
        .LSlen    (LSlen),
        .Sdata    (Sdata),
        .LOutEn   (LOutEn),
        .Ldata    (Ldata),
        .LSfree   (LSfree),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  dat;
    } wr_t;
    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];

    // RAM seen by the DUT, and the bench's own view of memory contents
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event with value %h, expected none (cycle %0d)", name, act, cyc);
    endtask

    // Byte RAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end

    // Monitor: pops expectations whenever the DUT shows a write byte or a completion
    wr_t   mon_w;
    done_t mon_d;
    bit    prev_out = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_out = 1'b0;
        end else begin
            if (prev_out) check("lsfree_after_done", {31'd0, LSfree}, 32'd1);
            prev_out = LOutEn;
            if (!mem_wr) check("dout_zero_when_idle", {24'd0, mem_dout}, 32'd0);
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    unexpected("unexpected_write", mem_a);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("wr_cycle", cyc, mon_w.cyc);
                    check("wr_addr", mem_a, mon_w.addr);
                    check("wr_data", {24'd0, mem_dout}, {24'd0, mon_w.dat});
                end
            end
            if (LOutEn) begin
                if (done_q.size() == 0) begin
                    unexpected("unexpected_loutEn", Ldata);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc, mon_d.cyc);
                    check("ldata", Ldata, mon_d.dat);
                end
            end
        end
    end

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    // Issue one request; pushes expectations computed from the memory model.
    task automatic issue(input logic rw, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] sd, input bit hold, input bit expect_done,
                         output int acc);
        int          n;
        int          w;
        int          k;
        logic [31:0] exp;
        logic [31:0] a;
        wr_t         wt;
        done_t       dt;
        n = nbytes(len);
        w = 0;
`ifdef MEMCTRL_IO_WAIT_EN
        if (addr[17:16] == 2'b11) w = 1;
`endif
        acc = -1;
        k = 0;
        @(negedge clk);
        while (!LSfree && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!LSfree) begin
            unexpected("lsfree_timeout", addr);
            return;
        end
        dataEn   = 1'b1;
        LSRW     = rw;
        dataAddr = addr;
        LSlen    = len;
        Sdata    = sd;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) dataEn = 1'b0;
        exp = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (rw) begin
                if (expect_done) begin
                    wt.cyc  = acc + w + i;
                    wt.addr = a;
                    wt.dat  = sd[8*i +: 8];
                    wr_q.push_back(wt);
                    ref_mem[a] = sd[8*i +: 8];
                end
            end else begin
                exp[8*i +: 8] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
            end
        end
        if (expect_done) begin
            dt.cyc = acc + w + n + (rw ? 0 : 1);
            dt.dat = exp;
            done_q.push_back(dt);
        end
        if (hold) begin
            k = 0;
            while (!LOutEn && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!LOutEn) unexpected("hold_done_timeout", addr);
            dataEn = 1'b0;
        end
    endtask

    initial begin
        int          acc;
        int          k;
        logic [31:0] base;
        logic [31:0] a;
        logic [7:0]  v;
        wr_t         wt;

        // preload three windows, one of them straddling the 32-bit wrap, one around 0x30000
        for (int wdw = 0; wdw < 3; wdw++) begin
            base = (wdw == 0) ? 32'h0000_0100 : (wdw == 1) ? 32'hFFFF_FFE0 : 32'h0002_FFE0;
            for (int i = 0; i < 64; i++) begin
                a = base + 32'(i);
                v = 8'($urandom);
                ram[a] = v;
                ref_mem[a] = v;
            end
        end

        // reset state
        repeat (2) @(negedge clk);
        check("rst_loutEn", {31'd0, LOutEn}, 32'd0);
        check("rst_ldata", Ldata, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("lsfree_after_reset", {31'd0, LSfree}, 32'd1);

        // directed: SW, LW, LB, LH, wrapping SW, SB in and out of the slow region
        issue(1'b1, 32'h0000_0100, 2'b11, 32'hA1B2C3D4, 1'b0, 1'b1, acc);
        issue(1'b0, 32'h0000_0100, 2'b11, 32'h0, 1'b0, 1'b1, acc);
        issue(1'b0, 32'h0000_0103, 2'b00, 32'h0, 1'b0, 1'b1, acc);
        issue(1'b0, 32'h0000_0102, 2'b01, 32'h0, 1'b0, 1'b1, acc);
        issue(1'b1, 32'hFFFF_FFFE, 2'b11, 32'h5566_7788, 1'b0, 1'b1, acc);
        issue(1'b0, 32'hFFFF_FFFE, 2'b11, 32'h0, 1'b0, 1'b1, acc);
        issue(1'b1, 32'h0003_0000, 2'b00, 32'h0000_00EE, 1'b0, 1'b1, acc);
        issue(1'b1, 32'h0000_0100, 2'b00, 32'h0000_0077, 1'b0, 1'b1, acc);
        issue(1'b0, 32'h0003_0000, 2'b00, 32'h0, 1'b0, 1'b1, acc);

        // dataEn held high for the whole access: exactly one access expected
        issue(1'b1, 32'h0000_0120, 2'b11, $urandom, 1'b1, 1'b1, acc);
        issue(1'b0, 32'h0000_0120, 2'b10, 32'h0, 1'b1, 1'b1, acc);

        // reset during byte 2 of a store
        issue(1'b1, 32'h0000_0200, 2'b11, 32'h1122_3344, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            wt.cyc  = acc + i;
            wt.addr = 32'h0000_0200 + 32'(i);
            wt.dat  = (i == 0) ? 8'h44 : (i == 1) ? 8'h33 : 8'h22;
            wr_q.push_back(wt);
        end
        ref_mem[32'h0000_0200] = 8'h44;
        ref_mem[32'h0000_0201] = 8'h33;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        dataEn = 1'b1;
        #1;
        check("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("midrst_mem_a", mem_a, 32'd0);
        check("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("midrst_loutEn", {31'd0, LOutEn}, 32'd0);
        check("midrst_ldata", Ldata, 32'd0);
        @(negedge clk);
        dataEn = 1'b0;
        check("midrst_hold_mem_a", mem_a, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("lsfree_after_midrst", {31'd0, LSfree}, 32'd1);
        check("no_done_after_midrst", {31'd0, LOutEn}, 32'd0);
        issue(1'b0, 32'h0000_0200, 2'b11, 32'h0, 1'b0, 1'b1, acc);

        // random traffic
        for (int t = 0; t < 200; t++) begin
            k = $urandom_range(0, 2);
            base = (k == 0) ? 32'h0000_0100 : (k == 1) ? 32'hFFFF_FFE0 : 32'h0002_FFE0;
            a = base + 32'($urandom_range(0, 63));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 7) == 0), 1'b1, acc);
        end

        // drain
        k = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("wr_queue_empty", wr_q.size(), 32'd0);
        check("done_queue_empty", done_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
